// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file:
// clear-engine state encoding, parameter defaults and a bus-field extractor.
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // Widest flattened bus / single field the extractor handles
    // (4 ports x 64 bits).
    localparam int BUS_MAX_W   = 256;
    localparam int FIELD_MAX_W = 64;

    // Returns field idx (each field 'width' bits) of a flattened bus.
    // Callers zero-extend the bus to BUS_MAX_W and truncate the result.
    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [BUS_MAX_W-1:0] bus,
        input int                   width,
        input int                   idx
    );
        logic [FIELD_MAX_W-1:0] mask;
        mask = (width >= FIELD_MAX_W) ? '1
                                      : ((FIELD_MAX_W'(1) << width) - FIELD_MAX_W'(1));
        return FIELD_MAX_W'(bus >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: decode-side read addresses, writeback write
// port, clear-engine request/status and the write-drop flag.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
);
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     clr_start;
    logic                     clr_busy;
    logic                     clr_done;
    logic                     wr_drop;

    modport master (
        output ra, we, wa, wd, clr_start,
        input  rd, clr_busy, clr_done, wr_drop
    );

    modport slave (
        input  ra, we, wa, wd, clr_start,
        output rd, clr_busy, clr_done, wr_drop
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear engine: IDLE -> SWEEP (one entry per cycle, pointer 0..DEPTH-1)
// -> DONE (one cycle) -> IDLE. Start requests outside IDLE are ignored.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_ptr,
    output logic              idle
);
    clr_state_t state;

    // State, pointer and the registered busy/done flags advance together.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLR_IDLE;
            clr_ptr  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            unique case (state)
                CLR_IDLE: begin
                    if (clr_start) begin
                        state    <= CLR_SWEEP;
                        clr_ptr  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    // The pointer stops on all-ones instead of wrapping.
                    if (clr_ptr == '1) begin
                        state    <= CLR_DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                CLR_DONE: begin
                    state    <= CLR_IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= CLR_IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    assign idle   = (state == CLR_IDLE);
    assign clr_en = (state == CLR_SWEEP);

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with optional hardwired-zero entry,
// sequenced clear engine and optional write-to-read bypass.
// Macro REGFILE_BYPASS_EN: when defined, an accepted write is forwarded to
// read ports addressing the same entry in the same cycle (write-first);
// otherwise reads return the stored value until the edge (read-first).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     idle;
    logic                     clr_en;
    logic [ADDR_W-1:0]        clr_ptr;
    logic                     clr_busy;
    logic                     clr_done;
    logic                     wr_acc;
    logic                     wr_eff;
    logic                     zero_hit;
    logic [NUM_RD*DATA_W-1:0] rd_flat;

    regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
        .clk       (clk),
        .reset     (reset),
        .clr_start (bus.clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .clr_en    (clr_en),
        .clr_ptr   (clr_ptr),
        .idle      (idle)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

    // Writes land only in IDLE with no start request in the same cycle;
    // a zero-register write is accepted but has no effect (not a drop).
    assign zero_hit    = ZERO_REG && (bus.wa == '0);
    assign wr_acc      = bus.we && idle && !bus.clr_start;
    assign wr_eff      = wr_acc && !zero_hit;
    assign bus.wr_drop = bus.we && (bus.clr_start || !idle);

    // Array update: reset zeroes everything, else the sweep or the write port.
    // NOTE: the array is reset explicitly, so it maps to flops, not a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_ptr] <= '0;
        end else if (wr_eff) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    // Per-port read mux with zero register, optional bypass and sweep blanking.
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        rd_flat = '0;
        addr    = '0;
        data    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr = ADDR_W'(get_field(BUS_MAX_W'(bus.ra), ADDR_W, k));
            data = mem[addr];
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_eff && (bus.wa == addr)) begin
                data = bus.wd;
            end
`endif
            if (!idle) begin
                data = '0;
            end
            rd_flat[k*DATA_W +: DATA_W] = data;
        end
    end

    assign bus.rd = rd_flat;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a default-size instance (ZERO_REG=1)
// and a small instance (16x8, four read ports, ZERO_REG=0) run side by side
// against a behavioural model; directed scenarios add literal expectations.
module tb_regfile_param;

    localparam int D0_DW = 32, D0_AW = 5, D0_NR = 2, D0_DEPTH = 32;
    localparam int D1_DW = 16, D1_AW = 3, D1_NR = 4, D1_DEPTH = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 1'b0;

    regfile_if #(.DATA_W(D0_DW), .ADDR_W(D0_AW), .NUM_RD(D0_NR)) bus0 ();
    regfile_if #(.DATA_W(D1_DW), .ADDR_W(D1_AW), .NUM_RD(D1_NR)) bus1 ();

    regfile_param #(.DATA_W(D0_DW), .ADDR_W(D0_AW), .NUM_RD(D0_NR), .ZERO_REG(1'b1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    regfile_param #(.DATA_W(D1_DW), .ADDR_W(D1_AW), .NUM_RD(D1_NR), .ZERO_REG(1'b0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Model: array contents plus a countdown of busy+done cycles left
    // (>1 busy, ==1 done, 0 idle). Entries are invisible during a sweep and
    // writes are dropped, so the model zeroes the whole array at start.
    logic [D0_DW-1:0] m0 [D0_DEPTH];
    logic [D1_DW-1:0] m1 [D1_DEPTH];
    int cnt0;
    int cnt1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [D0_DW-1:0] exp_rd0(input int k);
        logic [D0_AW-1:0] a;
        a = bus0.ra[k*D0_AW +: D0_AW];
        if (cnt0 != 0) return '0;
        if (a == 0) return '0;
        if (BYPASS && bus0.we && !bus0.clr_start && bus0.wa == a) return bus0.wd;
        return m0[a];
    endfunction

    function automatic logic [D1_DW-1:0] exp_rd1(input int k);
        logic [D1_AW-1:0] a;
        a = bus1.ra[k*D1_AW +: D1_AW];
        if (cnt1 != 0) return '0;
        if (BYPASS && bus1.we && !bus1.clr_start && bus1.wa == a) return bus1.wd;
        return m1[a];
    endfunction

    // Model update on every clock edge, cleared by reset.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                cnt0 = 0;
                cnt1 = 0;
                foreach (m0[i]) m0[i] = '0;
                foreach (m1[i]) m1[i] = '0;
            end else begin
                if (cnt0 > 0) cnt0--;
                else if (bus0.clr_start) begin
                    cnt0 = D0_DEPTH + 1;
                    foreach (m0[i]) m0[i] = '0;
                end else if (bus0.we && bus0.wa != 0) m0[bus0.wa] = bus0.wd;

                if (cnt1 > 0) cnt1--;
                else if (bus1.clr_start) begin
                    cnt1 = D1_DEPTH + 1;
                    foreach (m1[i]) m1[i] = '0;
                end else if (bus1.we) m1[bus1.wa] = bus1.wd;
            end
        end
    end

    // Compare every output against the model once per cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !reset) begin
                for (int k = 0; k < D0_NR; k++)
                    check($sformatf("d0_rd_p%0d", k), bus0.rd[k*D0_DW +: D0_DW], exp_rd0(k));
                check("d0_busy", bus0.clr_busy, cnt0 > 1);
                check("d0_done", bus0.clr_done, cnt0 == 1);
                check("d0_drop", bus0.wr_drop, bus0.we && (bus0.clr_start || cnt0 != 0));
                for (int k = 0; k < D1_NR; k++)
                    check($sformatf("d1_rd_p%0d", k), bus1.rd[k*D1_DW +: D1_DW], exp_rd1(k));
                check("d1_busy", bus1.clr_busy, cnt1 > 1);
                check("d1_done", bus1.clr_done, cnt1 == 1);
                check("d1_drop", bus1.wr_drop, bus1.we && (bus1.clr_start || cnt1 != 0));
            end
        end
    end

    task automatic idle_inputs();
        bus0.ra = '0; bus0.we = 1'b0; bus0.wa = '0; bus0.wd = '0; bus0.clr_start = 1'b0;
        bus1.ra = '0; bus1.we = 1'b0; bus1.wa = '0; bus1.wd = '0; bus1.clr_start = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        int done_seen;

        reset = 1'b1;
        idle_inputs();
        #2;
        // Reset state.
        check("rst_d0_busy", bus0.clr_busy, 0);
        check("rst_d0_done", bus0.clr_done, 0);
        check("rst_d0_rd", bus0.rd, 0);
        check("rst_d1_rd", bus1.rd, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Write 31 to entry 15, read back addresses 1..15 on port 0.
        bus0.we = 1'b1; bus0.wa = 5'd15; bus0.wd = 32'd31;
        tick();
        bus0.we = 1'b0;
        for (int a = 1; a <= 15; a++) begin
            bus0.ra[4:0] = 5'(a);
            #1;
            check($sformatf("wrrd_addr%0d", a), bus0.rd[31:0], (a == 15) ? 32'd31 : 32'd0);
            tick();
        end

        // Zero register: ignored on dut0 without a drop, stored on dut1.
        bus0.ra = '0; bus1.ra = '0;
        bus0.we = 1'b1; bus0.wa = '0; bus0.wd = 32'd255;
        bus1.we = 1'b1; bus1.wa = '0; bus1.wd = 16'd255;
        #1;
        check("zero_d0_drop", bus0.wr_drop, 0);
        check("zero_d1_drop", bus1.wr_drop, 0);
        tick();
        bus0.we = 1'b0; bus1.we = 1'b0;
        #1;
        check("zero_d0_rd", bus0.rd[31:0], 0);
        check("zero_d1_rd", bus1.rd[15:0], 16'd255);
        tick();

        // Same-cycle read/write on port 1.
        bus0.ra = {5'd1, 5'd0};
        bus0.we = 1'b1; bus0.wa = 5'd1; bus0.wd = 32'd255;
        #1;
        check("samecyc_rd", bus0.rd[63:32], BYPASS ? 32'd255 : 32'd0);
        tick();
        bus0.we = 1'b0;
        #1;
        check("samecyc_after", bus0.rd[63:32], 32'd255);
        tick();

        // Small build: 0xBEEF at entry 7 on all four ports, then an 8-cycle sweep.
        bus1.we = 1'b1; bus1.wa = 3'd7; bus1.wd = 16'hBEEF;
        tick();
        bus1.we = 1'b0;
        bus1.ra = {4{3'd7}};
        #1;
        for (int k = 0; k < D1_NR; k++)
            check($sformatf("beef_p%0d", k), bus1.rd[k*16 +: 16], 16'hBEEF);
        tick();
        bus1.clr_start = 1'b1;
        tick();
        bus1.clr_start = 1'b0;
        n = 0; guard = 0;
        while (bus1.clr_busy === 1'b1 && guard < 100) begin
            n++; guard++;
            tick();
        end
        check("d1_sweep_cycles", n, 8);
        check("d1_sweep_done", bus1.clr_done, 1);
        tick();
        check("d1_after_done", bus1.clr_done, 0);
        #1;
        check("d1_after_rd", bus1.rd[15:0], 0);
        tick();

        // Clear sweep on dut0 with a dropped write in the middle.
        for (int i = 1; i < D0_DEPTH; i++) begin
            bus0.we = 1'b1; bus0.wa = 5'(i); bus0.wd = 32'(i);
            tick();
        end
        bus0.we = 1'b0;
        bus0.clr_start = 1'b1;
        tick();
        bus0.clr_start = 1'b0;
        n = 0; guard = 0;
        while (bus0.clr_busy === 1'b1 && guard < 100) begin
            n++; guard++;
            if (n == 5) begin
                bus0.we = 1'b1; bus0.wa = 5'd3; bus0.wd = 32'd99; bus0.ra = {5'd3, 5'd3};
                #1;
                check("sweep_drop", bus0.wr_drop, 1);
                check("sweep_rd_blank", bus0.rd[31:0], 0);
            end else begin
                bus0.we = 1'b0;
            end
            tick();
        end
        bus0.we = 1'b0;
        check("d0_sweep_cycles", n, 32);
        check("d0_sweep_done", bus0.clr_done, 1);
        tick();
        check("d0_after_done", bus0.clr_done, 0);
        check("d0_after_busy", bus0.clr_busy, 0);
        for (int a = 0; a < D0_DEPTH; a++) begin
            bus0.ra = {5'(31 - a), 5'(a)};
            #1;
            check($sformatf("cleared_%0d", a), bus0.rd, 0);
            tick();
        end

        // Randomised traffic on both instances.
        for (int c = 0; c < 800; c++) begin
            bus0.we = 1'($urandom_range(0, 1));
            bus0.wa = 5'($urandom_range(0, 31));
            bus0.wd = $urandom;
            bus0.clr_start = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < D0_NR; k++)
                bus0.ra[k*D0_AW +: D0_AW] = ($urandom_range(0, 3) == 0) ? bus0.wa : 5'($urandom_range(0, 31));
            bus1.we = 1'($urandom_range(0, 1));
            bus1.wa = 3'($urandom_range(0, 7));
            bus1.wd = 16'($urandom);
            bus1.clr_start = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < D1_NR; k++)
                bus1.ra[k*D1_AW +: D1_AW] = ($urandom_range(0, 3) == 0) ? bus1.wa : 3'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        guard = 0;
        while ((cnt0 != 0 || cnt1 != 0) && guard < 100) begin
            guard++;
            tick();
        end
        check("quiesce_bound", guard < 100, 1);

        // Reset mid-sweep: busy falls at once, no done pulse, array zero.
        bus0.we = 1'b1; bus0.wa = 5'd9; bus0.wd = 32'hA5A5_0009;
        tick();
        bus0.we = 1'b0;
        bus0.clr_start = 1'b1;
        tick();
        bus0.clr_start = 1'b0;
        repeat (10) tick();
        check("midrst_busy_before", bus0.clr_busy, 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", bus0.clr_busy, 0);
        check("midrst_done", bus0.clr_done, 0);
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int a = 0; a < D0_DEPTH; a++) begin
            bus0.ra = {5'(a), 5'(a)};
            #1;
            check($sformatf("midrst_rd_%0d", a), bus0.rd, 0);
            if (bus0.clr_done === 1'b1) done_seen++;
            tick();
        end
        check("midrst_no_done", done_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file, successor to the fixed 32x32 two-read/one-write `RegisterFile`, for the processor datapath. It adds:
- configurable data width, address width and read-port count;
- an optional hardwired-zero register;
- a sequenced clear engine that sweeps every entry to zero, one per cycle, on request;
- optional write-to-read bypass.

It sits between the decode stage (read addresses) and the writeback stage (write port).

## Interface
Parameters:
- `DATA_W`, 32, bits per entry
- `ADDR_W`, 5, address width; DEPTH = 2**ADDR_W entries
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, when 1 entry 0 reads as 0 and ignores writes

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears every entry and the clear engine
- `ra`  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- `rd`  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- `we`  in  1  write enable
- `wa`  in  ADDR_W  write address
- `wd`  in  DATA_W  write data
- `clr_start`  in  1  one-cycle request to start a clear sweep
- `clr_busy`  out  1  high while the sweep is in progress
- `clr_done`  out  1  one-cycle pulse when the sweep completes
- `wr_drop`  out  1  combinational; high when a requested write is discarded

## Operation
- **Reads:** combinational from the array.
- **Write acceptance:** a write is accepted on the rising edge when `we`=1, the engine is in IDLE and `clr_start`=0.
- **Zero register:** when ZERO_REG=1, a write to `wa`=0 is silently ignored. It is not a drop, so `wr_drop`=0. Reads of address 0 return 0.
- **Clear engine states:**
  - IDLE -> SWEEP when `clr_start`=1; the pointer loads 0.
  - SWEEP: each cycle entry[ptr] is set to 0 and ptr is incremented. When ptr = DEPTH-1 is cleared, go to DONE.
  - DONE -> IDLE unconditionally after one cycle.
- **`wr_drop`:** `wr_drop` = `we` & (`clr_start` | state≠IDLE). A dropped write never modifies the array.
- **Reads during the sweep:** in SWEEP and DONE, every read port returns 0.
- **Repeated requests:** `clr_start` in SWEEP or DONE is ignored; it does not restart the sweep.
- **Same-cycle read/write:** a read of the address being written in the same cycle follows the Configuration section.
- **Width rules:**
  - addresses are unsigned, with no wrap or range check needed (full decode);
  - the sweep pointer is ADDR_W bits and terminates on all-ones; it never wraps.

## Timing
- **Reset values:**
  - all entries 0;
  - state IDLE, ptr 0;
  - `clr_busy`=0, `clr_done`=0;
  - `rd` = 0 on all ports.
- **Write latency:** data written at edge N is visible on `rd` after edge N, i.e. in cycle N+1 (same cycle only with bypass).
- **Sweep duration:**
  - `clr_start` sampled at edge N;
  - `clr_busy`=1 from after edge N for exactly DEPTH cycles;
  - `clr_done`=1 for the following single cycle;
  - IDLE, and writes accepted, from edge N+DEPTH+1.
- **Reset mid-sweep:** aborts immediately. The array is zeroed, the state returns to IDLE, and no `clr_done` pulse is produced.
- `clr_busy` and `clr_done` are registered (state decode); they are never high together.

## Configuration
- **Macro:** `REGFILE_BYPASS_EN`.
- **Defined:** when an accepted write targets address a while read port k has `ra`=a in the same cycle, `rd` port k returns `wd` combinationally (write-first). Dropped writes and ignored zero-register writes are not bypassed.
- **Undefined:** read-first; port k returns the old value until the edge.

## Structure
- **Package `regfile_pkg`:**
  - clear-engine state enum (IDLE, SWEEP, DONE);
  - defaults for DATA_W, ADDR_W and NUM_RD;
  - a function extracting field k from a flattened bus.
- **Sub-module `regfile_clr_fsm`:**
  - owns the state, the pointer, `clr_busy` and `clr_done`;
  - exports `clr_en` and `clr_ptr`, which drive the array's clear path;
  - exports `idle`, used for write gating and `wr_drop`.
- **Top:** holds the array, the write-acceptance logic, the read muxes and the bypass.

## Test plan
- **Write/read-back:** write `wd`=31 to `wa`=15 with defaults, then sweep `ra` port 0 from 1 to 15 -> `rd` port 0 = 31 only at address 15, 0 elsewhere.
- **Zero register:** with ZERO_REG=1, write 255 to `wa`=0 -> `rd`=0 at address 0, `wr_drop`=0. With ZERO_REG=0, `rd`=255.
- **Same-cycle read/write:** write 255 to `wa`=1 while port 1 `ra`=1 -> `rd`=255 in the same cycle with `REGFILE_BYPASS_EN` defined, old value (0) without it.
- **Clear sweep:** preload entries 1..31 with their own index, pulse `clr_start` -> `clr_busy`=1 for 32 cycles, then `clr_done`=1 for 1 cycle; afterwards all reads return 0. A `we` during the sweep gives `wr_drop`=1 and the array is unchanged.
- **Reset mid-sweep:** assert `reset` asynchronously 10 cycles into the sweep -> `clr_busy` falls without waiting for a clock, `clr_done` never pulses, and all entries read 0.
- **Parametrised build:** DATA_W=16, ADDR_W=3, NUM_RD=4; write 16'hBEEF to address 7 -> all four ports with `ra`=7 return 16'hBEEF, and a sweep takes 8 cycles.
